leftshift_multicycle: RTL and testbench

Multicycle logical left shifter for the ALU shift path, producing `sll` results over five clocked stages instead of one combinational cascade. It applies shift amounts of 16, 8, 4, 2 and 1 bits, one per cycle, selected by the corresponding bit of the shift amount, and fills vacated low bits with zeros. A start/ready handshake connects it to the ALU control, which uses `busy` to stall issue while a shift is in flight.

---
 rtl/leftshift_multicycle_if.sv | 28 ++
 rtl/leftshift_multicycle.sv | 97 +++++++++
 tb/tb_leftshift_multicycle.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/leftshift_multicycle_if.sv
// Start/ready handshake bundle between the ALU control and the multicycle
// left shifter: operands and start in, registered result, ready and busy out.
interface leftshift_multicycle_if;
   logic        ctrl_start;
   logic [31:0] data_operandA;
   logic [4:0]  ctrl_shiftamt;
   logic [31:0] data_result;
   logic        data_resultRDY;
   logic        busy;

   modport master (
      output ctrl_start,
      output data_operandA,
      output ctrl_shiftamt,
      input  data_result,
      input  data_resultRDY,
      input  busy
   );

   modport slave (
      input  ctrl_start,
      input  data_operandA,
      input  ctrl_shiftamt,
      output data_result,
      output data_resultRDY,
      output busy
   );
endinterface

// File: rtl/leftshift_multicycle.sv
// Multicycle logical left shifter (sll). The captured operand is shifted by
// 16, 8, 4, 2 and 1 bits over five cycles, each step enabled by the matching
// bit of the captured shift amount. Vacated low bits fill with zeros.
module leftshift_multicycle (
   input  logic                  clock,
   input  logic                  reset,
   leftshift_multicycle_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_next;
   logic        load;
   logic [2:0]  stage_q;
   logic [31:0] w_q;
   logic [4:0]  s_q;
   logic [31:0] w_shift;
   logic [31:0] result_q;
   logic        rdy_q;
   logic        busy_q;

   // Next state and operand-capture decision; start is only honoured in IDLE/DONE.
   always_comb begin
      state_next = IDLE;
      load       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ctrl_start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            state_next = (stage_q == 3'd0) ? DONE : SHIFT;
         end
         DONE: begin
            if (bus.ctrl_start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One shift step: stage k shifts by 2^k when S[k] is set, else passes W through.
   always_comb begin
      w_shift = w_q;
      case (stage_q)
         3'd4: if (s_q[4]) w_shift = {w_q[15:0], 16'h0000};
         3'd3: if (s_q[3]) w_shift = {w_q[23:0], 8'h00};
         3'd2: if (s_q[2]) w_shift = {w_q[27:0], 4'h0};
         3'd1: if (s_q[1]) w_shift = {w_q[29:0], 2'b00};
         3'd0: if (s_q[0]) w_shift = {w_q[30:0], 1'b0};
         default: w_shift = w_q;
      endcase
   end

   // State, working registers and registered outputs; reset aborts any shift.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         stage_q  <= 3'd0;
         w_q      <= 32'h0000_0000;
         s_q      <= 5'd0;
         result_q <= 32'h0000_0000;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q <= state_next;
         busy_q  <= (state_next == SHIFT);
         rdy_q   <= (state_next == DONE);
         if (load) begin
            w_q     <= bus.data_operandA;
            s_q     <= bus.ctrl_shiftamt;
            stage_q <= 3'd4;
         end else if (state_q == SHIFT) begin
            w_q <= w_shift;
            if (stage_q == 3'd0) begin
               result_q <= w_shift;
            end else begin
               stage_q <= stage_q - 3'd1;
            end
         end
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.busy           = busy_q;

endmodule

// File: tb/tb_leftshift_multicycle.sv
// Directed bench for leftshift_multicycle: latency, zero/all shift amounts,
// ignored starts, asynchronous abort, back-to-back issue and a full sweep.
module tb_leftshift_multicycle;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   leftshift_multicycle_if bus ();

   leftshift_multicycle dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   // Issue one start, then wait (bounded) for the ready pulse.
   task automatic run_shift(input logic [31:0] op, input logic [4:0] sh,
                            output logic [31:0] res, output int lat,
                            output int busy_gaps, output int overlap);
      bus.ctrl_start    = 1'b1;
      bus.data_operandA = op;
      bus.ctrl_shiftamt = sh;
      step();
      bus.ctrl_start = 1'b0;
      lat       = 0;
      busy_gaps = 0;
      overlap   = 0;
      while (!bus.data_resultRDY && lat < 12) begin
         if (!bus.busy) busy_gaps++;
         step();
         lat++;
      end
      if (bus.busy && bus.data_resultRDY) overlap++;
      res = bus.data_result;
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] base;
      logic [31:0] expv;
      int lat, gaps, ovl, pulses;

      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.ctrl_start    = 1'b0;
      bus.data_operandA = 32'h0;
      bus.ctrl_shiftamt = 5'd0;
      #12;
      chk("rst_result", bus.data_result, 32'h0);
      chk("rst_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
      chk("rst_busy", {31'b0, bus.busy}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      step();

      // 1 << 31
      run_shift(32'h0000_0001, 5'd31, res, lat, gaps, ovl);
      chk("s31_result", res, 32'h8000_0000);
      chk("s31_latency", lat, 32'd5);
      chk("s31_busy", gaps, 32'd0);
      chk("s31_overlap", ovl, 32'd0);
      step();
      chk("s31_rdy_fall", {31'b0, bus.data_resultRDY}, 32'h0);
      chk("s31_hold", bus.data_result, 32'h8000_0000);

      // all ones by 4
      run_shift(32'hFFFF_FFFF, 5'd4, res, lat, gaps, ovl);
      chk("s4_result", res, 32'hFFFF_FFF0);
      chk("s4_latency", lat, 32'd5);
      step();

      // zero shift still takes five stages
      run_shift(32'h1234_5678, 5'd0, res, lat, gaps, ovl);
      chk("s0_result", res, 32'h1234_5678);
      chk("s0_latency", lat, 32'd5);
      chk("s0_busy", gaps, 32'd0);
      step();

      // start during SHIFT ignored, inputs churn after capture
      bus.ctrl_start    = 1'b1;
      bus.data_operandA = 32'h0000_000F;
      bus.ctrl_shiftamt = 5'd8;
      step();
      bus.ctrl_start    = 1'b0;
      bus.data_operandA = 32'h5555_0000;
      bus.ctrl_shiftamt = 5'd3;
      step();
      bus.ctrl_start    = 1'b1;
      bus.data_operandA = 32'hAAAA_AAAA;
      bus.ctrl_shiftamt = 5'd1;
      step();
      bus.ctrl_start = 1'b0;
      pulses = 0;
      res    = 32'h0;
      for (int i = 0; i < 12; i++) begin
         bus.data_operandA = 32'h0101_0101 * (i + 1);
         bus.ctrl_shiftamt = 5'(i * 7);
         if (bus.data_resultRDY) begin
            pulses++;
            res = bus.data_result;
         end
         step();
      end
      chk("ign_result", res, 32'h0000_0F00);
      chk("ign_pulses", pulses, 32'd1);
      chk("ign_idle_busy", {31'b0, bus.busy}, 32'h0);

      // asynchronous reset between E3 and E4
      bus.ctrl_start    = 1'b1;
      bus.data_operandA = 32'h0000_0003;
      bus.ctrl_shiftamt = 5'd5;
      step();
      bus.ctrl_start = 1'b0;
      step();
      step();
      step();
      chk("abort_busy_before", {31'b0, bus.busy}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_busy", {31'b0, bus.busy}, 32'h0);
      chk("abort_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
      chk("abort_result", bus.data_result, 32'h0);
      step();
      reset  = 1'b0;
      pulses = 0;
      gaps   = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.data_resultRDY) pulses++;
         if (bus.busy) gaps++;
      end
      chk("abort_no_pulse", pulses, 32'd0);
      chk("abort_idle", gaps, 32'd0);
      chk("abort_result_after", bus.data_result, 32'h0);

      // back-to-back: start held high through DONE
      bus.ctrl_start    = 1'b1;
      bus.data_operandA = 32'h0000_0001;
      bus.ctrl_shiftamt = 5'd1;
      step();
      bus.ctrl_shiftamt = 5'd2;
      lat = 0;
      while (!bus.data_resultRDY && lat < 12) begin
         step();
         lat++;
      end
      chk("b2b_first_result", bus.data_result, 32'h0000_0002);
      chk("b2b_first_latency", lat, 32'd5);
      step();
      bus.ctrl_start = 1'b0;
      chk("b2b_busy_restart", {31'b0, bus.busy}, 32'h1);
      chk("b2b_rdy_fall", {31'b0, bus.data_resultRDY}, 32'h0);
      lat = 1;
      while (!bus.data_resultRDY && lat < 14) begin
         step();
         lat++;
      end
      chk("b2b_second_result", bus.data_result, 32'h0000_0004);
      chk("b2b_spacing", lat, 32'd6);
      step();

      // sweep of all shift amounts
      base = 32'hDEAD_BEEF;
      for (int n = 0; n < 32; n++) begin
         run_shift(base, 5'(n), res, lat, gaps, ovl);
         expv = base << n;
         chk($sformatf("sweep%0d", n), res, expv);
         if (lat != 5) chk($sformatf("sweep%0d_latency", n), lat, 32'd5);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
